// File: rtl/serial_tx.sv
// serial_tx: parallel-in, serial-out framed transmitter.
// Frame: idle-high line, one start bit (0), WIDTH data bits LSB first, one stop bit (1),
// every bit held CLKS_PER_BIT clocks. Words are accepted over a valid/ready handshake.
// Optional feature macro SERIAL_TX_PARITY_EN: inserts an even-parity bit between data and stop.
module serial_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_out,
    output logic             tx_busy,
    output logic             tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t             state, state_d;
    logic [CNT_W-1:0]   clk_cnt, clk_cnt_d;
    logic [IDX_W-1:0]   bit_idx, bit_idx_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic               bit_end;
`ifdef SERIAL_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    // Last clock of the current bit period; with CLKS_PER_BIT=1 every cycle is a bit boundary.
    assign bit_end = (clk_cnt == CNT_LAST);

    // State and datapath registers; reset takes priority over a same-cycle handshake.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples
        // the values from before this edge, independent of statement order.
        if (reset) begin
            // NOTE: the shift register is reset along with the control state so a frame
            // aborted by reset leaves no stale data behind.
            state   <= IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shift_q <= '0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            clk_cnt <= clk_cnt_d;
            bit_idx <= bit_idx_d;
            shift_q <= shift_d;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state / next-datapath logic and registered-state output decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d   = state;
        clk_cnt_d = clk_cnt;
        bit_idx_d = bit_idx;
        shift_d   = shift_q;
`ifdef SERIAL_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        tx_out    = 1'b1;

        unique case (state)
            IDLE: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (tx_valid) begin
                    shift_d = tx_data;
                    state_d = START;
`ifdef SERIAL_TX_PARITY_EN
                    parity_d = ^tx_data;
`endif
                end
            end
            START: begin
                tx_out = 1'b0;
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = DATA;
                end else begin
                    clk_cnt_d = clk_cnt + 1'b1;
                end
            end
            DATA: begin
                tx_out = shift_q[0];
                if (bit_end) begin
                    clk_cnt_d = '0;
                    shift_d   = shift_q >> 1;
                    if (bit_idx == IDX_LAST) begin
                        bit_idx_d = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt + 1'b1;
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                tx_out = parity_q;
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = STOP;
                end else begin
                    clk_cnt_d = clk_cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                tx_out = 1'b1;
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    clk_cnt_d = clk_cnt + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and status flags decode the registered state only.
    assign tx_ready = (state == IDLE);
    assign tx_busy  = !tx_ready;
    assign tx_done  = (state == STOP) && bit_end;

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: self-checking bench for serial_tx.
// The reference model expands each accepted word into its expected per-cycle line levels
// and done flags (a queue); an empty queue means the transmitter is idle and ready.
module tb_serial_tx;

    localparam int W = 8;
`ifdef SERIAL_TX_PARITY_EN
    localparam int CPB = 1;
    localparam int NBITS = W + 3;
`else
    localparam int CPB = 4;
    localparam int NBITS = W + 2;
`endif
    localparam int FRAME_LEN = NBITS * CPB;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         tx_out;
    logic         tx_busy;
    logic         tx_done;

    int n_tests = 0;
    int n_fail  = 0;

    bit q_out[$];
    bit q_done[$];
    int since_hs = 0;

    serial_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_out   (tx_out),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected frame for one word: start, data LSB first, optional even parity, stop.
    task automatic push_frame(input logic [W-1:0] w);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < W; i++) bits.push_back(w[i]);
`ifdef SERIAL_TX_PARITY_EN
        bits.push_back(^w);
`endif
        bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++) begin
            for (int j = 0; j < CPB; j++) begin
                q_out.push_back(bits[b]);
                q_done.push_back((b == bits.size() - 1) && (j == CPB - 1));
            end
        end
    endtask

    // One clock cycle, run at the falling edge: check this cycle's outputs against the
    // model, then drive the inputs for the next rising edge and update the model.
    task automatic cycle(input bit rst, input bit vld, input logic [W-1:0] d);
        bit idle, exp_out, exp_done;
        since_hs++;
        idle = (q_out.size() == 0);
        if (idle) begin
            exp_out  = 1'b1;
            exp_done = 1'b0;
        end else begin
            exp_out  = q_out.pop_front();
            exp_done = q_done.pop_front();
        end
        check("tx_out",   32'(tx_out),   32'(exp_out));
        check("tx_done",  32'(tx_done),  32'(exp_done));
        check("tx_ready", 32'(tx_ready), 32'(idle));
        check("tx_busy",  32'(tx_busy),  32'(!idle));
        if (tx_done === 1'b1) check("done_cycle", since_hs, FRAME_LEN);

        reset    = rst;
        tx_valid = vld;
        tx_data  = d;
        if (rst) begin
            q_out.delete();
            q_done.delete();
        end else if (idle && vld) begin
            push_frame(d);
            since_hs = 0;
        end
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, W'($urandom));
    endtask

    initial begin
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state, with a handshake attempt that reset must win over.
        cycle(1'b1, 1'b1, 8'h99);
        cycle(1'b0, 1'b0, '0);
        idle_cycles(2);

        // Single frame 0xA5, then 0x07 (parity 1 when enabled).
        cycle(1'b0, 1'b1, 8'hA5);
        idle_cycles(FRAME_LEN + 2);
        cycle(1'b0, 1'b1, 8'h07);
        idle_cycles(FRAME_LEN + 2);

        // Back-to-back: valid held high, 0x00 then 0xFF.
        cycle(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < FRAME_LEN + 1; i++) cycle(1'b0, 1'b1, 8'hFF);
        idle_cycles(FRAME_LEN + 3);

        // Valid while busy: 0x3C pulses mid-frame and in the last stop cycle of 0x81.
        cycle(1'b0, 1'b1, 8'h81);
        for (int i = 1; i <= FRAME_LEN + 4; i++)
            cycle(1'b0, (i == 10) || (i == 11) || (i == FRAME_LEN), (i < 12 || i == FRAME_LEN) ? 8'h3C : 8'h00);
        idle_cycles(2);

        // Reset during data bit 3 of 0x55, then a clean frame of 0x0F.
        cycle(1'b0, 1'b1, 8'h55);
        for (int i = 1; i < CPB * 4 + 1; i++) cycle(1'b0, 1'b0, 8'h55);
        cycle(1'b1, 1'b0, 8'h55);
        cycle(1'b1, 1'b0, 8'h55);
        idle_cycles(3);
        cycle(1'b0, 1'b1, 8'h0F);
        idle_cycles(FRAME_LEN + 2);

        // Random traffic with noisy data, sporadic valid and a 2-cycle reset in the middle.
        for (int i = 0; i < 600; i++)
            cycle((i == 301) || (i == 302), ($urandom_range(0, 3) == 0), W'($urandom));
        idle_cycles(FRAME_LEN + 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
